// File: rtl/bundle_decoder_if.sv
//------------------------------------------------------------------------------
// Module      : bundle_decoder_if
// Description : Handshake/result bus between the bundle fabric and the decoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bundle_decoder_if #(
    parameter int N = 10
) ();
    logic [N-1:0]             bundle_i;
    logic                     bundle_valid_i;
    logic                     bundle_ready_o;
    logic                     bit_o;
    logic                     ambiguous_o;
    logic [$clog2(N+1)-1:0]   ones_o;
    logic                     valid_o;
    logic                     ready_i;

    modport slave (
        input  bundle_i, bundle_valid_i, ready_i,
        output bundle_ready_o, bit_o, ambiguous_o, ones_o, valid_o
    );

    modport master (
        output bundle_i, bundle_valid_i, ready_i,
        input  bundle_ready_o, bit_o, ambiguous_o, ones_o, valid_o
    );
endinterface

`default_nettype wire

// File: rtl/bundle_decoder.sv
//------------------------------------------------------------------------------
// Module      : bundle_decoder
// Description : Serial CHUNK-per-cycle popcount of an N-wire bundle with von
//               Neumann threshold decision. Optional statistics: BUNDLE_STATS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bundle_decoder #(
    parameter int N         = 10,
    parameter int CHUNK     = 2,
    parameter int LO_THRESH = 3,
    parameter int HI_THRESH = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    bundle_decoder_if.slave   bus
`ifdef BUNDLE_STATS_EN
    ,
    input  logic              stats_clr_i,
    output logic [15:0]       ambig_cnt_o,
    output logic [31:0]       minority_cnt_o
`endif
);

    localparam int K  = (N + CHUNK - 1) / CHUNK;
    localparam int SW = K * CHUNK;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
    localparam logic [CW-1:0] HI_C     = CW'(HI_THRESH);
    localparam logic [CW-1:0] LO_C     = CW'(LO_THRESH);
    localparam logic [CW-1:0] HALF_C   = CW'(N / 2);
    localparam logic [CW-1:0] N_C      = CW'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   shadow_q, shadow_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            bit_q, bit_d;
    logic            amb_q, amb_d;
    logic [CW-1:0]   ones_q, ones_d;

    logic [CW-1:0]   chunk_ones;
    logic [CW-1:0]   total;
    logic            dec_bit;
    logic            dec_amb;

    // The shadow is zero-padded to K*CHUNK wires and shifted down each cycle,
    // so the low CHUNK bits are always the current chunk and the tail is masked.
    always_comb begin
        chunk_ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_ones = chunk_ones + CW'(shadow_q[i]);
        end
        total = acc_q + chunk_ones;
    end

    // A tie (2c == N) in the ambiguous band resolves to 0.
    always_comb begin
        dec_bit = 1'b0;
        dec_amb = 1'b0;
        if (total >= HI_C) begin
            dec_bit = 1'b1;
        end else if (total > LO_C) begin
            dec_amb = 1'b1;
            dec_bit = (total > HALF_C);
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        amb_d    = amb_q;
        ones_d   = ones_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.bundle_valid_i) begin
                    shadow_d = SW'(bus.bundle_i);
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ST_COUNT;
                end
            end
            ST_COUNT: begin
                acc_d    = total;
                shadow_d = shadow_q >> CHUNK;
                idx_d    = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    bit_d   = dec_bit;
                    amb_d   = dec_amb;
                    ones_d  = total;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            bit_q    <= 1'b0;
            amb_q    <= 1'b0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            amb_q    <= amb_d;
            ones_q   <= ones_d;
        end
    end

    assign bus.bundle_ready_o = (state_q == ST_IDLE);
    assign bus.valid_o        = (state_q == ST_DONE);
    assign bus.bit_o          = bit_q;
    assign bus.ambiguous_o    = amb_q;
    assign bus.ones_o         = ones_q;

`ifdef BUNDLE_STATS_EN
    logic [15:0]   ambig_q, ambig_d;
    logic [31:0]   minority_q, minority_d;
    logic          finish;
    logic [CW-1:0] minority_add;
    logic [32:0]   minority_sum;

    always_comb begin
        finish       = (state_q == ST_COUNT) && (idx_q == LAST_IDX);
        minority_add = dec_bit ? (N_C - total) : total;
        minority_sum = {1'b0, minority_q} + 33'(minority_add);
        ambig_d      = ambig_q;
        minority_d   = minority_q;
        if (stats_clr_i) begin
            ambig_d    = '0;
            minority_d = '0;
        end else if (finish) begin
            if (dec_amb && (ambig_q != 16'hFFFF)) begin
                ambig_d = ambig_q + 16'd1;
            end
            minority_d = minority_sum[32] ? 32'hFFFF_FFFF : minority_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ambig_q    <= '0;
            minority_q <= '0;
        end else begin
            ambig_q    <= ambig_d;
            minority_q <= minority_d;
        end
    end

    assign ambig_cnt_o    = ambig_q;
    assign minority_cnt_o = minority_q;
`endif

endmodule

`default_nettype wire
